// File: rtl/ext_pipe_if.sv
// Request/result handshake bundle for ext_pipe: immediate request in, extended result out.
interface ext_pipe_if #(
    parameter int N = 24,
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_imm;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_ext;
    logic         out_carry;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_ext, out_carry
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_ext, out_carry
    );
endinterface

// File: rtl/ext_pipe.sv
// Two-stage immediate extender (S1 capture, S2 result) with valid/ready flow control.
// Optional macro EXT_PIPE_ROT_IMM_EN turns mode 00 into an 8-bit rotated immediate with carry-out.
module ext_pipe #(
    parameter int N = 24,
    parameter int W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    ext_pipe_if.slave   bus
);

    logic         vld_p1_q, vld_p1_d;
    logic         vld_p2_q, vld_p2_d;
    logic [N-1:0] imm_p1_q;
    logic [1:0]   mode_p1_q;
    logic [W-1:0] ext_p2_q;
    logic         carry_p2_q;
    logic [W:0]   res_d;
    logic         adv;
    logic         in_rdy;

    // Returns {carry, extended value} for one immediate/mode pair.
    function automatic logic [W:0] extend(input logic [N-1:0] imm, input logic [1:0] mode);
        logic signed [N+1:0] br;
        logic signed [15:0]  h16;
        logic [31:0]         rot;
        logic                cy;
        logic [W:0]          res;
`ifdef EXT_PIPE_ROT_IMM_EN
        logic [4:0]          amt;
        logic [63:0]         dbl;
`endif
        br  = {imm, 2'b00};
        h16 = imm[15:0];
        rot = {24'd0, imm[7:0]};
        cy  = 1'b0;
`ifdef EXT_PIPE_ROT_IMM_EN
        amt = {imm[11:8], 1'b0};
        dbl = {rot, rot} >> amt;
        rot = dbl[31:0];
        cy  = (amt != 5'd0) && rot[31];
`endif
        res = '0;
        case (mode)
            2'b00:   res = {cy, W'(rot)};
            2'b01:   res = {1'b0, W'(imm[11:0])};
            2'b10:   res = {1'b0, W'(br)};
            default: res = {1'b0, W'(h16)};
        endcase
        return res;
    endfunction

    // S1 may load whenever it is empty or moving into S2 this cycle.
    assign adv      = !vld_p2_q || bus.out_ready;
    assign in_rdy   = !vld_p1_q || adv;
    assign vld_p1_d = in_rdy ? bus.in_valid : vld_p1_q;
    assign vld_p2_d = adv ? vld_p1_q : vld_p2_q;
    assign res_d    = extend(imm_p1_q, mode_p1_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    // S1: capture raw request
    always_ff @(posedge clk) begin
        if (in_rdy && bus.in_valid) begin
            imm_p1_q  <= bus.in_imm;
            mode_p1_q <= bus.in_mode;
        end
    end

    // S2: extended result
    always_ff @(posedge clk) begin
        if (adv && vld_p1_q) begin
            ext_p2_q   <= res_d[W-1:0];
            carry_p2_q <= res_d[W];
        end
    end

    // Data registers carry no reset, so outputs are qualified by valid.
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_p2_q;
    assign bus.out_ext   = vld_p2_q ? ext_p2_q : '0;
    assign bus.out_carry = vld_p2_q && carry_p2_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Randomized bench for ext_pipe with a queue-based arithmetic reference model.
module tb_ext_pipe;
    localparam int N = 24;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ext_pipe_if #(.N(N), .W(W)) bus ();
    ext_pipe #(.N(N), .W(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic [W-1:0] ext;
        logic         cy;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Reference: plain integer arithmetic on the immediate, one case per mode.
    function automatic exp_t model(input logic [N-1:0] imm, input logic [1:0] mode);
        exp_t   e;
        longint v;
        longint r;
        int     sh;
        e.cy = 1'b0;
        e.acc = 0;
        r = 0;
        case (mode)
            2'd0: begin
                v = longint'(imm[7:0]);
`ifdef EXT_PIPE_ROT_IMM_EN
                sh = 2 * int'(imm[11:8]);
                r = ((v >> sh) | (v << (32 - sh))) & 64'hFFFF_FFFF;
                if (sh != 0) e.cy = r[31];
`else
                sh = 0;
                r = v + longint'(sh);
`endif
            end
            2'd1: r = longint'(imm[11:0]);
            2'd2: begin
                v = longint'(imm);
                if (imm[N-1]) v = v - (longint'(1) << N);
                r = v * 4;
            end
            default: begin
                v = longint'(imm[15:0]);
                if (imm[15]) v = v - 65536;
                r = v;
            end
        endcase
        e.ext = r[W-1:0];
        return e;
    endfunction

    // One clock cycle: drive at negedge, compare settled outputs, update model, advance.
    task automatic step(input logic v, input logic [N-1:0] imm, input logic [1:0] mode,
                        input logic ordy, output logic accepted);
        logic exp_rdy;
        logic exp_vld;
        exp_t e;
        bus.in_valid  = v;
        bus.in_imm    = imm;
        bus.in_mode   = mode;
        bus.out_ready = ordy;
        #1;
        exp_rdy = (sb.size() < 2) || ordy;
        exp_vld = (sb.size() > 0) && (cyc >= sb[0].acc + 2);
        check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        check("out_valid", 64'(bus.out_valid), 64'(exp_vld));
        if (exp_vld) begin
            check("out_ext", 64'(bus.out_ext), 64'(sb[0].ext));
            check("out_carry", 64'(bus.out_carry), 64'(sb[0].cy));
        end
        if (exp_vld && ordy) void'(sb.pop_front());
        accepted = v && exp_rdy;
        if (accepted) begin
            e = model(imm, mode);
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [N-1:0] imm, input logic [1:0] mode);
        logic a;
        step(1'b1, imm, mode, 1'b1, a);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 2'd0, 1'b1, a);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_ext", 64'(bus.out_ext), 64'd0);
        check("rst_out_carry", 64'(bus.out_carry), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic         a;
        logic [31:0]  rnd;
        logic [N-1:0] imm;
        int           tries;

        bus.in_valid = 1'b0;
        bus.in_imm = '0;
        bus.in_mode = 2'd0;
        bus.out_ready = 1'b1;
        #3;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors, back to back, then drain.
        send(N'(24'h0000AB), 2'd0);
        send(N'(24'hFFFFFE), 2'd2);
        send(N'(24'h000003), 2'd2);
        send(N'(24'h008001), 2'd3);
        send(N'(24'hFFFABC), 2'd1);
`ifdef EXT_PIPE_ROT_IMM_EN
        send(N'(24'h0004FF), 2'd0);
        send(N'(24'h0000FF), 2'd0);
`endif
        idle(3);

        // Back-pressure: four requests held until accepted, consumer stalled for a while.
        tries = 0;
        for (int i = 0; i < 4; i++) begin
            rnd = $urandom();
            imm = rnd[N-1:0];
            do begin
                step(1'b1, imm, 2'(i), (tries >= 6), a);
                tries++;
            end while (!a && tries < 40);
            check("bp_accept", 64'(a), 64'd1);
        end
        idle(4);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom();
            step(rnd[31:30] != 2'b00, rnd[N-1:0], rnd[25:24], rnd[29:28] != 2'b00, a);
        end

        // Fill both stages, then assert reset between clock edges.
        step(1'b1, N'(24'h123456), 2'd2, 1'b0, a);
        step(1'b1, N'(24'h00F00F), 2'd3, 1'b0, a);
        bus.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        send(N'(24'h000077), 2'd1);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            rnd = $urandom();
            step(rnd[31], rnd[N-1:0], rnd[25:24], rnd[30:29] != 2'b00, a);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 SHALL have parameter N, default 24: width of the immediate input field; legal range 16..30.
REQ-002 SHALL have parameter W, default 32: width of the extended output; legal when W >= 32 and W >= N+2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1: in_imm/in_mode carry a request.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the request this cycle.
REQ-007 SHALL have port in_imm, input, N: raw instruction immediate field.
REQ-008 SHALL have port in_mode, input, 2: extension mode, 00 imm8, 01 imm12, 10 branch imm, 11 imm16 signed.
REQ-009 SHALL have port out_valid, output, 1: out_ext/out_carry hold a result.
REQ-010 SHALL have port out_ready, input, 1: the consumer takes the result this cycle.
REQ-011 SHALL have port out_ext, output, W: extended immediate.
REQ-012 SHALL have port out_carry, output, 1: shifter carry-out of the rotated immediate.

Function
REQ-013 SHALL transfer an input when in_valid and in_ready are both 1 on a rising clk; SHALL transfer an output when out_valid and out_ready are both 1.
REQ-014 SHALL be a two-stage pipeline (S1 capture register, S2 result register); result appears on out_* 2 cycles after acceptance, with no bubble at a steady out_ready=1.
REQ-015 SHALL drive in_ready = !S1.valid | !S2.valid | out_ready, combinationally, with no dependence on in_valid.
REQ-016 SHALL advance S1 into S2 when S2 is empty or S2 transfers that same cycle; otherwise S1 and S2 hold, and out_* stay stable while out_valid=1 and out_ready=0.
REQ-017 SHALL, for mode 00, output the imm8 in_imm[7:0] zero-extended to W (see REQ-025 for the rotate variant); out_carry=0.
REQ-018 SHALL, for mode 01, output in_imm[11:0] zero-extended to W; out_carry=0.
REQ-019 SHALL, for mode 10, output {in_imm[N-1:0],2'b00} sign-extended from bit N+1 to W; out_carry=0.
REQ-020 SHALL, for mode 11, output in_imm[15:0] sign-extended from bit 15 to W; out_carry=0.
REQ-021 SHALL accept a new input in the same cycle an output transfers, with the pipeline full (throughput 1/cycle).
REQ-022 SHALL ignore in_imm/in_mode when in_valid=0; SHALL never duplicate or drop a transferred request; results SHALL leave in acceptance order.

Reset
REQ-023 SHALL, while reset_n=0, clear S1.valid and S2.valid immediately (asynchronously), forcing out_valid=0, out_ext=0 and out_carry=0; in_ready SHALL read 1.
REQ-024 SHALL discard any request in flight at reset assertion; the first request accepted after reset_n rises SHALL appear 2 cycles after acceptance.

Configuration
REQ-025 SHALL, with macro EXT_PIPE_ROT_IMM_EN defined, compute mode 00 as the 32-bit rotate-right of in_imm[7:0] by 2*in_imm[11:8], zero-extended to W, with out_carry = bit 31 of the rotated value when the rotate amount is nonzero and 0 when it is zero.
REQ-026 SHALL, without EXT_PIPE_ROT_IMM_EN, ignore in_imm[11:8] in mode 00 and compute REQ-017 behaviour; out_carry SHALL be constant 0.

Verification
REQ-027 SHALL pass the check: reset, out_ready=1, send in_imm=0x0000AB in mode 00 (no macro) -> out_ext=0x000000AB exactly 2 cycles later, out_carry=0.
REQ-028 SHALL pass the check: send mode 10 with in_imm=0xFFFFFE -> out_ext=0xFFFFFFF8; then send in_imm=0x000003 -> out_ext=0x0000000C.
REQ-029 SHALL pass the check: send mode 11 with in_imm=0x008001 -> out_ext=0xFFFF8001; then send mode 01 with in_imm=0xFFFABC -> out_ext=0x00000ABC.
REQ-030 SHALL pass the check: with the macro defined, send mode 00 with in_imm=0x0004FF -> out_ext=0xFF000000 and out_carry=1; then send in_imm=0x0000FF -> out_ext=0x000000FF and out_carry=0.
REQ-031 SHALL pass the check: hold out_ready=0 and stream 4 requests -> only 2 accepted, in_ready=0, out_* stable; then raise out_ready -> all 4 results in order with no loss.
REQ-032 SHALL pass the check: assert reset_n=0 mid-stream between clock edges -> out_valid=0 at once with no clock edge; after release the earlier requests SHALL never appear.
